usb_serial_reg_bridge: RTL and testbench
========================================

USB_SERIAL_REG_BRIDGE -- requirements
Module: usbSerialRegBridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 48000, max idle cycles in WR_DATA before abandoning a write (1 ms at 48 MHz).
REQ-002 SHALL have ports: i_clk  input  1  sole clock, 48 MHz domain of usbFullSpeedSerial.
REQ-003 SHALL have ports: i_rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-004 SHALL have ports: i_hostToDev_data  input  8  byte from usbFullSpeedSerial o_hostToDev_data.
REQ-005 SHALL have ports: i_hostToDev_valid  input  1  byte valid.
REQ-006 SHALL have ports: o_hostToDev_ready  output  1  bridge accepts byte.
REQ-007 SHALL have ports: o_devToHost_data  output  8  reply byte to usbFullSpeedSerial i_devToHost_data.
REQ-008 SHALL have ports: o_devToHost_valid  output  1  reply valid.
REQ-009 SHALL have ports: i_devToHost_ready  input  1  reply accepted.
REQ-010 SHALL have ports: o_regAddr  output  7  register address.
REQ-011 SHALL have ports: o_regWrEn  output  1  single-cycle write strobe.
REQ-012 SHALL have ports: o_regWrData  output  8  write data.
REQ-013 SHALL have ports: o_regRdEn  output  1  single-cycle read strobe.
REQ-014 SHALL have ports: i_regRdData  input  8  read data, valid exactly one cycle after o_regRdEn.

Function
REQ-015 A byte SHALL transfer on hostToDev only in a cycle where valid && ready; likewise devToHost.
REQ-016 Command byte SHALL be {rnw[7], addr[6:0]}; rnw=1 read, rnw=0 write.
REQ-017 All outputs SHALL be driven from flops (no combinational input-to-output path).
REQ-018 States: IDLE, WR_DATA, WR_STROBE, RD_STROBE, RD_WAIT, RD_RESP; exactly one active (onehot or binary, implementer's choice).
REQ-019 IDLE: o_hostToDev_ready=1; on transfer, o_regAddr <= byte[6:0]; rnw=0 -> WR_DATA, rnw=1 -> RD_STROBE.
REQ-020 WR_DATA: o_hostToDev_ready=1; on transfer, o_regWrData <= byte, -> WR_STROBE; timeout counter cleared on entry.
REQ-021 WR_DATA timeout: counter increments each cycle without transfer; when it reaches TIMEOUT_CYCLES-1 with no transfer, -> IDLE, no write issued.
REQ-022 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1; SHALL saturate, never wrap.
REQ-023 WR_STROBE: o_regWrEn=1 for exactly one cycle, o_hostToDev_ready=0, -> IDLE; write latency = 1 cycle after data-byte transfer.
REQ-024 RD_STROBE: o_regRdEn=1 for exactly one cycle, ready=0, -> RD_WAIT.
REQ-025 RD_WAIT: capture i_regRdData into o_devToHost_data, -> RD_RESP.
REQ-026 RD_RESP: o_devToHost_valid=1, data stable until transfer; on i_devToHost_ready, valid falls next cycle, -> IDLE.
REQ-027 o_hostToDev_ready SHALL be 0 in WR_STROBE, RD_STROBE, RD_WAIT, RD_RESP; host bytes arriving then are back-pressured, never dropped.
REQ-028 o_regWrEn and o_regRdEn SHALL never be high simultaneously.
REQ-029 o_regAddr/o_regWrData SHALL hold last value outside strobes.
REQ-030 Read reply SHALL be returned exactly once per read command; no reply for writes.

Reset
REQ-031 While i_rst_n=0: state IDLE; o_hostToDev_ready=0 during reset, 1 from first clock edge after deassert; o_devToHost_valid=0; o_regWrEn=0; o_regRdEn=0; o_regAddr=0; o_regWrData=0; o_devToHost_data=0; counter=0.
REQ-032 Reset asserted mid-transaction SHALL abort it immediately, with no strobe or reply afterwards.

Verification
REQ-033 Write: bytes 0x05,0xA5 back-to-back -> one cycle after second transfer o_regWrEn=1, o_regAddr=0x05, o_regWrData=0xA5, single pulse.
REQ-034 Read: byte 0x85, i_regRdData=0x3C -> o_regRdEn pulse with o_regAddr=0x05, then o_devToHost_valid=1, data=0x3C; hold ready=0 for 10 cycles -> data/valid stable, one transfer.
REQ-035 Timeout: byte 0x12 then silence for TIMEOUT_CYCLES cycles -> no o_regWrEn, back in IDLE; next 0x12,0x77 -> write addr 0x12 data 0x77.
REQ-036 Back-pressure: host valid held high with 0x81,0x02,0x99 during read reply stall -> 0x02 not accepted until reply transfer; then write addr 0x02 data 0x99.
REQ-037 Reset: assert i_rst_n=0 in RD_WAIT -> no o_devToHost_valid after release; all outputs per REQ-031.
REQ-038 Loopback with usbFullSpeedSerial and host transactor: 100 random write/read pairs to a 128x8 register model -> every read reply equals last written value.

Source files
------------

// File: rtl/usb_serial_reg_bridge.sv
// Byte-stream to register-bus bridge: turns {rnw, addr} command bytes from the USB
// serial endpoint into single-cycle register strobes, and returns one reply byte per read.
module usb_serial_reg_bridge #(
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_hostToDev_data,
  input  logic       i_hostToDev_valid,
  output logic       o_hostToDev_ready,
  output logic [7:0] o_devToHost_data,
  output logic       o_devToHost_valid,
  input  logic       i_devToHost_ready,
  output logic [6:0] o_regAddr,
  output logic       o_regWrEn,
  output logic [7:0] o_regWrData,
  output logic       o_regRdEn,
  input  logic [7:0] i_regRdData
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_STROBE,
    RD_STROBE,
    RD_WAIT,
    RD_RESP
  } stateT;

  stateT state, nextState;
  logic [CW-1:0] timeoutCount;
  logic hostXfer;
  logic devXfer;

  assign hostXfer = i_hostToDev_valid && o_hostToDev_ready;
  assign devXfer  = o_devToHost_valid && i_devToHost_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A data byte arriving on the final timeout cycle still wins over the abandon.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (hostXfer) nextState = i_hostToDev_data[7] ? RD_STROBE : WR_DATA;
      WR_DATA: begin
        if (hostXfer) begin
          nextState = WR_STROBE;
        end else if (timeoutCount >= LAST_COUNT) begin
          nextState = IDLE;
        end
      end
      WR_STROBE: nextState = IDLE;
      RD_STROBE: nextState = RD_WAIT;
      RD_WAIT:   nextState = RD_RESP;
      RD_RESP:   if (devXfer) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so nothing leaks combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hostToDev_ready <= 1'b0;
      o_regWrEn         <= 1'b0;
      o_regRdEn         <= 1'b0;
      o_devToHost_valid <= 1'b0;
      o_regAddr         <= '0;
      o_regWrData       <= '0;
      o_devToHost_data  <= '0;
    end else begin
      o_hostToDev_ready <= (nextState == IDLE) || (nextState == WR_DATA);
      o_regWrEn         <= (nextState == WR_STROBE);
      o_regRdEn         <= (nextState == RD_STROBE);
      o_devToHost_valid <= (nextState == RD_RESP);
      if (state == IDLE && hostXfer) begin
        o_regAddr <= i_hostToDev_data[6:0];
      end
      if (state == WR_DATA && hostXfer) begin
        o_regWrData <= i_hostToDev_data;
      end
      if (state == RD_WAIT) begin
        o_devToHost_data <= i_regRdData;
      end
    end
  end

  // Counter is zero whenever WR_DATA is not being held, so every entry starts fresh.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeoutCount <= '0;
    end else if (state != WR_DATA || nextState != WR_DATA) begin
      timeoutCount <= '0;
    end else if (timeoutCount != '1) begin
      timeoutCount <= timeoutCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_serial_reg_bridge.sv
// Directed bench for usb_serial_reg_bridge: write, read, timeout, back-pressure and
// reset-abort sequences, with a small register responder driving read data.
module tb_usb_serial_reg_bridge;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rstN;
  logic [7:0] hostData;
  logic       hostValid;
  logic       hostReady;
  logic [7:0] devData;
  logic       devValid;
  logic       devReady;
  logic [6:0] regAddr;
  logic       regWrEn;
  logic [7:0] regWrData;
  logic       regRdEn;
  logic [7:0] regRdData;

  logic [7:0] rdValue;
  int checks = 0;
  int errors = 0;
  int wrCount = 0;
  int rdCount = 0;
  int replyCount = 0;
  int bothHigh = 0;

  usb_serial_reg_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_hostToDev_data  (hostData),
    .i_hostToDev_valid (hostValid),
    .o_hostToDev_ready (hostReady),
    .o_devToHost_data  (devData),
    .o_devToHost_valid (devValid),
    .i_devToHost_ready (devReady),
    .o_regAddr         (regAddr),
    .o_regWrEn         (regWrEn),
    .o_regWrData       (regWrData),
    .o_regRdEn         (regRdEn),
    .i_regRdData       (regRdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register responder: read data is only meaningful the cycle after a read strobe.
  always @(posedge clk) begin
    regRdData <= regRdEn ? rdValue : 8'hEE;
  end

  always @(posedge clk) begin
    if (regWrEn) wrCount++;
    if (regRdEn) rdCount++;
    if (devValid && devReady) replyCount++;
    if (regWrEn && regRdEn) bothHigh++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one host byte and returns on the negedge after it was accepted.
  task automatic applyStimulus(input logic [7:0] b);
    logic accepted;
    accepted = 1'b0;
    hostData = b;
    hostValid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (hostReady) accepted = 1'b1;
      @(negedge clk);
    end
    hostValid = 1'b0;
    checkOutput("hostAccept", 32'(accepted), 32'd1);
  endtask

  initial begin
    rstN = 1'b0;
    hostData = 8'h00;
    hostValid = 1'b0;
    devReady = 1'b0;
    rdValue = 8'h00;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rstReady", 32'(hostReady), 32'd0);
    checkOutput("rstValid", 32'(devValid), 32'd0);
    checkOutput("rstWrEn", 32'(regWrEn), 32'd0);
    checkOutput("rstRdEn", 32'(regRdEn), 32'd0);
    checkOutput("rstAddr", 32'(regAddr), 32'd0);
    checkOutput("rstWrData", 32'(regWrData), 32'd0);
    checkOutput("rstDevData", 32'(devData), 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterRst", 32'(hostReady), 32'd1);

    $display("[TB] write 0x05 <- 0xA5");
    applyStimulus(8'h05);
    applyStimulus(8'hA5);
    checkOutput("wrStrobe", 32'(regWrEn), 32'd1);
    checkOutput("wrAddr", 32'(regAddr), 32'h05);
    checkOutput("wrData", 32'(regWrData), 32'hA5);
    checkOutput("wrReadyLow", 32'(hostReady), 32'd0);
    @(negedge clk);
    checkOutput("wrPulseEnd", 32'(regWrEn), 32'd0);
    checkOutput("wrCount1", 32'(wrCount), 32'd1);
    checkOutput("wrAddrHold", 32'(regAddr), 32'h05);

    $display("[TB] read 0x05 -> 0x3C with stalled reply");
    rdValue = 8'h3C;
    applyStimulus(8'h85);
    checkOutput("rdStrobe", 32'(regRdEn), 32'd1);
    checkOutput("rdAddr", 32'(regAddr), 32'h05);
    checkOutput("rdNoWr", 32'(regWrEn), 32'd0);
    @(negedge clk);
    checkOutput("rdPulseEnd", 32'(regRdEn), 32'd0);
    checkOutput("rdWaitNoValid", 32'(devValid), 32'd0);
    @(negedge clk);
    checkOutput("rspValid", 32'(devValid), 32'd1);
    checkOutput("rspData", 32'(devData), 32'h3C);
    repeat (10) @(negedge clk);
    checkOutput("rspValidHeld", 32'(devValid), 32'd1);
    checkOutput("rspDataHeld", 32'(devData), 32'h3C);
    checkOutput("rspReadyLow", 32'(hostReady), 32'd0);
    checkOutput("rspNoXferYet", 32'(replyCount), 32'd0);
    devReady = 1'b1;
    @(negedge clk);
    devReady = 1'b0;
    checkOutput("rspValidDrop", 32'(devValid), 32'd0);
    checkOutput("replyCount1", 32'(replyCount), 32'd1);
    checkOutput("rdCount1", 32'(rdCount), 32'd1);
    checkOutput("idleReady", 32'(hostReady), 32'd1);

    $display("[TB] data byte on the last timeout cycle");
    applyStimulus(8'h20);
    repeat (TIMEOUT - 1) @(negedge clk);
    applyStimulus(8'h5A);
    checkOutput("lateWrStrobe", 32'(regWrEn), 32'd1);
    checkOutput("lateWrAddr", 32'(regAddr), 32'h20);
    checkOutput("lateWrData", 32'(regWrData), 32'h5A);
    @(negedge clk);

    $display("[TB] write timeout");
    applyStimulus(8'h12);
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("toNoWrite", 32'(wrCount), 32'd2);
    applyStimulus(8'h12);
    checkOutput("toCmdNoStrobe", 32'(regWrEn), 32'd0);
    applyStimulus(8'h77);
    checkOutput("toWrStrobe", 32'(regWrEn), 32'd1);
    checkOutput("toWrAddr", 32'(regAddr), 32'h12);
    checkOutput("toWrData", 32'(regWrData), 32'h77);
    @(negedge clk);
    checkOutput("wrCount3", 32'(wrCount), 32'd3);

    $display("[TB] back-pressure during read reply");
    rdValue = 8'h44;
    applyStimulus(8'h81);
    hostData = 8'h02;
    hostValid = 1'b1;
    checkOutput("bpReadyStrobe", 32'(hostReady), 32'd0);
    repeat (7) @(negedge clk);
    checkOutput("bpReadyStall", 32'(hostReady), 32'd0);
    checkOutput("bpValid", 32'(devValid), 32'd1);
    checkOutput("bpData", 32'(devData), 32'h44);
    checkOutput("bpAddrHeld", 32'(regAddr), 32'h01);
    devReady = 1'b1;
    applyStimulus(8'h02);
    devReady = 1'b0;
    applyStimulus(8'h99);
    checkOutput("bpWrStrobe", 32'(regWrEn), 32'd1);
    checkOutput("bpWrAddr", 32'(regAddr), 32'h02);
    checkOutput("bpWrData", 32'(regWrData), 32'h99);
    checkOutput("replyCount2", 32'(replyCount), 32'd2);
    @(negedge clk);

    $display("[TB] reset during RD_WAIT");
    rdValue = 8'h55;
    applyStimulus(8'h85);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("abortReady", 32'(hostReady), 32'd0);
    checkOutput("abortValid", 32'(devValid), 32'd0);
    checkOutput("abortRdEn", 32'(regRdEn), 32'd0);
    checkOutput("abortAddr", 32'(regAddr), 32'd0);
    checkOutput("abortWrData", 32'(regWrData), 32'd0);
    checkOutput("abortDevData", 32'(devData), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    devReady = 1'b1;
    repeat (6) @(negedge clk);
    devReady = 1'b0;
    checkOutput("abortNoValid", 32'(devValid), 32'd0);
    checkOutput("abortNoReply", 32'(replyCount), 32'd2);
    checkOutput("abortIdleReady", 32'(hostReady), 32'd1);
    checkOutput("wrCountFinal", 32'(wrCount), 32'd4);
    checkOutput("rdCountFinal", 32'(rdCount), 32'd3);
    checkOutput("noDualStrobe", 32'(bothHigh), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
